// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: register map and address width.
// Optional feature macro used by this slice: GPIO_DEBOUNCE_EN.
package gpio_pkg;

  localparam int GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OUT      = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OE       = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IN       = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IRQ_EN   = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IRQ_STAT = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_EDGE_SEL = 3'd5;

endpackage

// File: rtl/gpio_pin_in.sv
// One GPIO pin input path: synchroniser chain, optional debounce, edge detector.
// With GPIO_DEBOUNCE_EN defined, the level only follows the synchronised pin after
// it has held a new value for DEBOUNCE_CYCLES consecutive cycles.
module gpio_pin_in #(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_level;
  logic                   r_prev;

  // Shift the raw pad level through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: rst_n is sampled at the clock edge only (synchronous), and state uses <=
    // so every flop in the chain captures its neighbour's pre-edge value.
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Count consecutive cycles the synchronised pin differs from the debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = w_sync;
`endif

  // Remember last cycle's level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/gpio_port.sv
// Bidirectional GPIO port: register bank, pad tristates, edge interrupt and read mux.
// Optional debounce of the input path is enabled with GPIO_DEBOUNCE_EN.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [GPIO_ADDR_W-1:0] addr,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  inout  wire  [WIDTH-1:0]       IO,
  output logic                   irq
);

  logic [WIDTH-1:0] r_out, r_oe, r_irq_en, r_irq_stat, r_edge_sel, r_rd_data;
  logic             r_irq;
  logic [WIDTH-1:0] w_level, w_rise, w_fall, w_ev, w_w1c, w_rd_mux;

  // Per-pin input path and pad driver.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_pin_in #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_pin (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_pad  (IO[gi]),
      .o_level(w_level[gi]),
      .o_rise (w_rise[gi]),
      .o_fall (w_fall[gi])
    );

    assign IO[gi] = r_oe[gi] ? r_out[gi] : 1'bz;
  end

  assign w_ev  = (r_edge_sel & w_rise) | (~r_edge_sel & w_fall);
  assign w_w1c = (wr_en && addr == GPIO_ADDR_IRQ_STAT) ? wr_data : '0;

  // Host-writable configuration registers; IN and unused addresses ignore writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_oe       <= '0;
      r_irq_en   <= '0;
      r_edge_sel <= '0;
    end else if (wr_en) begin
      case (addr)
        GPIO_ADDR_OUT:      r_out      <= wr_data;
        GPIO_ADDR_OE:       r_oe       <= wr_data;
        GPIO_ADDR_IRQ_EN:   r_irq_en   <= wr_data;
        GPIO_ADDR_EDGE_SEL: r_edge_sel <= wr_data;
        default: ;
      endcase
    end
  end

  // Sticky status: enabled edges set bits, W1C clears them, a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) r_irq_stat <= '0;
    else        r_irq_stat <= (r_irq_stat & ~w_w1c) | (w_ev & r_irq_en);
  end

  // Registered interrupt line.
  always_ff @(posedge clk) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= |(r_irq_stat & r_irq_en);
  end

  // Select the register addressed by a read.
  always_comb begin
    // NOTE: the default is assigned first so every path drives w_rd_mux and no latch forms.
    w_rd_mux = '0;
    case (addr)
      GPIO_ADDR_OUT:      w_rd_mux = r_out;
      GPIO_ADDR_OE:       w_rd_mux = r_oe;
      GPIO_ADDR_IN:       w_rd_mux = w_level;
      GPIO_ADDR_IRQ_EN:   w_rd_mux = r_irq_en;
      GPIO_ADDR_IRQ_STAT: w_rd_mux = r_irq_stat;
      GPIO_ADDR_EDGE_SEL: w_rd_mux = r_edge_sel;
      default:            w_rd_mux = '0;
    endcase
  end

  // Read data is captured on rd_en and held until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_rd_data <= '0;
    else if (rd_en) r_rd_data <= w_rd_mux;
  end

  assign rd_data = r_rd_data;
  assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the register/pad rules.
`timescale 1ns/1ps
module tb_gpio_port;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [2:0]   addr    = '0;
  logic         wr_en   = 1'b0;
  logic         rd_en   = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic         irq;
  wire  [W-1:0] io_pad;
  logic [W-1:0] ext_val = '1;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [W-1:0] m_out = '0, m_oe = '0, m_en = '0, m_stat = '0, m_sel = '0, m_rd = '0;
  logic         m_irq = 1'b0;
  logic [W-1:0] m_s = '0, m_lvl = '0, m_prev = '0;
  logic [W-1:0] pad_hist[$];
  int           run_len [W];
  bit           m_valid = 1'b0;

  gpio_port #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .IO     (io_pad),
    .irq    (irq)
  );

  // The outside world drives every pin the port is not driving.
  for (genvar gi = 0; gi < W; gi++) begin : g_ext
    assign io_pad[gi] = m_oe[gi] ? 1'bz : ext_val[gi];
  end

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_pad();
    return (m_oe & m_out) | (~m_oe & ext_val);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: advance one clock using the register-map and edge rules.
  always @(posedge clk) begin : model_step
    logic [W-1:0] pad, ev, w1c, rdv;
    pad = exp_pad();
    if (!rst_n) begin
      m_out = '0; m_oe = '0; m_en = '0; m_stat = '0; m_sel = '0; m_rd = '0;
      m_irq = 1'b0; m_s = '0; m_lvl = '0; m_prev = '0;
      pad_hist.delete();
      for (int k = 0; k < SYNC; k++) pad_hist.push_back('0);
      for (int k = 0; k < W; k++) run_len[k] = 0;
    end else begin
      ev  = (m_sel & m_lvl & ~m_prev) | (~m_sel & ~m_lvl & m_prev);
      w1c = (wr_en && addr == 3'd4) ? wr_data : '0;
      m_irq = |(m_stat & m_en);
      case (addr)
        3'd0:    rdv = m_out;
        3'd1:    rdv = m_oe;
        3'd2:    rdv = m_lvl;
        3'd3:    rdv = m_en;
        3'd4:    rdv = m_stat;
        3'd5:    rdv = m_sel;
        default: rdv = '0;
      endcase
      if (rd_en) m_rd = rdv;
      m_stat = (m_stat & ~w1c) | (ev & m_en);
      m_prev = m_lvl;
`ifdef GPIO_DEBOUNCE_EN
      for (int k = 0; k < W; k++) begin
        if (m_s[k] != m_lvl[k]) run_len[k]++;
        else                    run_len[k] = 0;
        if (run_len[k] == DEB) begin
          m_lvl[k]   = m_s[k];
          run_len[k] = 0;
        end
      end
`endif
      pad_hist.push_back(pad);
      void'(pad_hist.pop_front());
      m_s = pad_hist[0];
`ifndef GPIO_DEBOUNCE_EN
      m_lvl = m_s;
`endif
      if (wr_en) begin
        case (addr)
          3'd0:    m_out = wr_data;
          3'd1:    m_oe  = wr_data;
          3'd3:    m_en  = wr_data;
          3'd5:    m_sel = wr_data;
          default: ;
        endcase
      end
    end
    m_valid = 1'b1;
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("rd_data", 32'(rd_data), 32'(m_rd));
      check("irq",     32'(irq),     32'(m_irq));
      check("io_pad",  32'(io_pad),  32'(exp_pad()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [W-1:0] d);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  initial begin : stimulus
    logic [W-1:0] v;

    // Reset with all pads pulled high from outside.
    rst_n = 1'b0; ext_val = '1;
    repeat (3) tick();
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_irq",     32'(irq),     32'h0);
    check("reset_io_z",    32'(io_pad),  32'hFF);
    rst_n = 1'b1;
    repeat (SYNC) tick();
    do_read(3'd2, v);
    check("in_after_reset", 32'(v), 32'hFF);

    // Drive the low nibble.
    do_write(3'd1, 8'h0F);
    do_write(3'd0, 8'hA5);
    check("io_low_nibble", 32'(io_pad), 32'hF5);
    do_read(3'd0, v);
    check("read_out", 32'(v), 32'hA5);
    repeat (SYNC) tick();
    do_read(3'd2, v);
    check("in_readback", 32'(v), 32'hF5);

    // Rising edge on pin 0 with its interrupt enabled.
    do_write(3'd1, 8'h00);
    ext_val = 8'h00;
    repeat (4) tick();
    do_write(3'd5, 8'h01);
    do_write(3'd3, 8'h01);
    ext_val[0] = 1'b1;
    repeat (SYNC) tick();
    check("irq_before_set", 32'(irq), 32'h0);
    repeat (2) tick();
    check("irq_after_edge", 32'(irq), 32'h1);
    do_read(3'd4, v);
    check("stat_set", 32'(v), 32'h01);
    do_write(3'd4, 8'h01);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);
    do_read(3'd4, v);
    check("stat_cleared", 32'(v), 32'h00);

    // Falling edge on a disabled pin is not recorded.
    ext_val[1] = 1'b1;
    repeat (4) tick();
    ext_val[1] = 1'b0;
    repeat (5) tick();
    check("disabled_irq", 32'(irq), 32'h0);
    do_read(3'd4, v);
    check("disabled_stat", 32'(v), 32'h00);

    // Edge and W1C of the same bit on the same clock: the set wins.
    ext_val[0] = 1'b0;
    repeat (4) tick();
    ext_val[0] = 1'b1;
    repeat (2) tick();
    do_write(3'd4, 8'h01);
    do_read(3'd4, v);
    check("set_beats_w1c", 32'(v), 32'h01);
    do_write(3'd4, 8'hFF);

    // Reset during a write of OE discards the write.
    addr = 3'd1; wr_data = 8'hFF; wr_en = 1'b1; rst_n = 1'b0;
    tick();
    wr_en = 1'b0; rst_n = 1'b1;
    check("rst_mid_write_io", 32'(io_pad), 32'h01);
    do_read(3'd1, v);
    check("rst_mid_write_oe", 32'(v), 32'h00);

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch is filtered, a long level passes.
    repeat (30) tick();
    ext_val[2] = 1'b1;
    repeat (5) tick();
    ext_val[2] = 1'b0;
    repeat (25) tick();
    do_read(3'd2, v);
    check("debounce_glitch", 32'(v), 32'h01);
    ext_val[2] = 1'b1;
    repeat (20) tick();
    do_read(3'd2, v);
    check("debounce_level", 32'(v), 32'h05);
`endif

    // Randomized traffic, pad activity and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      addr    = 3'($urandom_range(0, 7));
      wr_en   = ($urandom_range(0, 3) == 0);
      rd_en   = 1'($urandom_range(0, 1));
      wr_data = W'($urandom);
      if ($urandom_range(0, 3) == 0) ext_val = ext_val ^ (W'(1) << $urandom_range(0, W - 1));
      rst_n   = ($urandom_range(0, 499) != 0);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
